cmd_load_engine: RTL and testbench
==================================

// Module: cmd_load_engine
// PURPOSE
//  Responder side of the command-pulse/BUSY handshake. Consumes the one-hot CMD pulses from the
//  command decoder for LOAD_VERTEX_BEGIN/CONT (bits 2/3) and LOAD_EDGE_BEGIN/CONT (bits 4/5).
//  Drives BUSY[2]/BUSY[4] back to the decoder and streams payload words into vertex/edge RAM.
//  Runs two independent load sessions, one for vertex and one for edge.
// PARAMETERS
//  VTX_AW          10      vertex RAM address width (depth 2**VTX_AW words)
//  EDG_AW          10      edge RAM address width (depth 2**EDG_AW words)
//  TIMEOUT_CYCLES  4096    idle cycles between CONTs before a session aborts; 0 disables the timeout
// PORTS
//  CLK            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  CMD            in   8       one-hot command pulses; at most one bit set per cycle
//  payload        in   32      packet payload, valid in every cycle a CMD bit is set
//  BUSY           out  8       bit2 = vertex session active, bit4 = edge session active, others 0
//  vtx_we         out  1       vertex RAM write strobe (1 cycle)
//  vtx_addr       out  VTX_AW  vertex RAM write address
//  vtx_wdata      out  32      vertex RAM write data
//  edg_we         out  1       edge RAM write strobe (1 cycle)
//  edg_addr       out  EDG_AW  edge RAM write address
//  edg_wdata      out  32      edge RAM write data
//  load_done      out  2       1-cycle pulse when a session completes; [0] = vertex, [1] = edge
//  err_overflow   out  2       sticky: BEGIN rejected, base+count exceeds depth; [0] = vtx, [1] = edg
//  err_timeout    out  2       sticky: session aborted by timeout; [0] = vtx, [1] = edg
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, both sessions IDLE, counters and pointers cleared.
//  - Per session, FSM IDLE -> LOAD -> IDLE. BUSY bit = (state == LOAD), registered.
//  - BEGIN in IDLE: payload[31:16] = base addr, payload[15:0] = count N.
//    * N == 0: stay IDLE, load_done pulses in cycle t+1, no write.
//    * base+N > 2**AW (computed 17-bit, no wrap): stay IDLE, set err_overflow in t+1.
//    * Otherwise enter LOAD in t+1: ptr = base, remaining = N, timeout counter = 0.
//  - BEGIN while in LOAD: ignored, no state change.
//  - CONT in LOAD at cycle t: in t+1, we=1, addr=ptr, wdata=payload. Then ptr+1, remaining-1,
//    timeout counter = 0.
//  - Final CONT (remaining == 1): write, BUSY clear and load_done pulse all occur in the same cycle
//    t+1. A new BEGIN is accepted from t+1 onward.
//  - CONT in IDLE: ignored, no write. The decoder gates it; this block also guards against it.
//  - Timeout: in LOAD with no CONT, the counter increments each cycle. When it reaches
//    TIMEOUT_CYCLES-1: go IDLE, BUSY clear, err_timeout set, no load_done. Partial writes remain.
//    If a CONT arrives in the cycle the timeout would fire, the CONT wins and the counter reloads.
//  - CLEAN (CMD[1]) clears err_overflow and err_timeout. It does not abort an active session.
//  - Sessions are independent and may overlap. Their write ports are separate, so there is no
//    arbitration. CMD is one-hot, so at most one write occurs per cycle overall.
//  - CMD[0], CMD[6] and CMD[7] are ignored.
//  - Reset mid-load: immediate abort, all state cleared, no done or error pulses.
// STRUCTURE
//  - Shared package gpu_cmd_pkg holds the CMD bit indices (SWAP=0, CLEAN=1, LVB=2, LVC=3,
//    LEB=4, LEC=5) and the opcode constants 8'h01..8'h06. Both the decoder and this block use it.
//  - Sub-module load_session #(AW, TIMEOUT_CYCLES) holds the FSM, pointer, remaining count,
//    timeout counter and write register. Instantiate it twice, for vertex and edge.
//  - Top level: CMD bit steering, BUSY assembly and sticky error flags.
// TESTING
//  1. Vertex BEGIN base=0x010, N=3, then 3 CONTs with 0xA0, 0xA1, 0xA2 -> writes to
//     0x010, 0x011, 0x012 at t+1. BUSY[2]=1 from the cycle after BEGIN and clears with the third
//     write. load_done[0] pulses once.
//  2. Edge BEGIN base=0x3FE, N=3 (AW=10) -> err_overflow[1]=1, BUSY[4] stays 0, no writes.
//     Then CLEAN -> err_overflow=0.
//  3. Interleaved: vertex BEGIN N=2, edge BEGIN N=2, then CONTs V,E,V,E -> correct addr/data on
//     each port. BUSY[2] and BUSY[4] overlap. Both load_done bits fire.
//  4. TIMEOUT_CYCLES=8: BEGIN N=4, 1 CONT, then idle -> after 8 idle cycles BUSY[2]=0 and
//     err_timeout[0]=1, exactly 1 write. A CONT on cycle 7 instead keeps the session alive.
//  5. BEGIN N=0 -> load_done pulse at t+1, BUSY never set. A stray CONT while IDLE -> no write.
//  6. rst_n low mid-load (2 of 5 written) -> BUSY=0 immediately. After release, a fresh BEGIN
//     restarts cleanly at its new base.

Source files
------------

// File: rtl/gpu_cmd_pkg.sv
// CMD bit positions and opcode values shared by the command decoder and the load engine.
package gpu_cmd_pkg;
  localparam int CMD_SWAP  = 0;
  localparam int CMD_CLEAN = 1;
  localparam int CMD_LVB   = 2;
  localparam int CMD_LVC   = 3;
  localparam int CMD_LEB   = 4;
  localparam int CMD_LEC   = 5;

  localparam logic [7:0] OP_SWAP  = 8'h01;
  localparam logic [7:0] OP_CLEAN = 8'h02;
  localparam logic [7:0] OP_LVB   = 8'h03;
  localparam logic [7:0] OP_LVC   = 8'h04;
  localparam logic [7:0] OP_LEB   = 8'h05;
  localparam logic [7:0] OP_LEC   = 8'h06;
endpackage

// File: rtl/load_session.sv
// One RAM load session: BEGIN opens a window of N words, each CONT writes one word at t+1.
// Busy, write strobe and done are registered; overflow/timeout hits are same-cycle flags for the parent.
module load_session #(
  parameter int AW             = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_begin,
  input  logic          cmd_cont,
  input  logic [31:0]   payload,
  output logic          busy,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata,
  output logic          done,
  output logic          ovf_hit,
  output logic          tmo_hit
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;
  localparam int          TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] DEPTH = 17'(1) << AW;

  logic [0:0]    state;
  logic [AW-1:0] ptr;
  logic [15:0]   remaining;
  logic [TW-1:0] tcnt;
  logic [16:0]   span;

  // 17-bit sum so a window ending exactly at the top of RAM is still legal
  assign span    = {1'b0, payload[31:16]} + {1'b0, payload[15:0]};
  assign ovf_hit = cmd_begin && (state == S_IDLE) && (payload[15:0] != 16'd0) && (span > DEPTH);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (state == S_LOAD) && !cmd_cont && (tcnt == TLAST);
  assign busy    = (state == S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      tcnt      <= '0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      done      <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_begin) begin
            if (payload[15:0] == 16'd0) begin
              done <= 1'b1;
            end else if (!ovf_hit) begin
              state     <= S_LOAD;
              ptr       <= payload[16+AW-1:16];
              remaining <= payload[15:0];
              tcnt      <= '0;
            end
          end
        end
        default: begin
          if (cmd_cont) begin
            we        <= 1'b1;
            addr      <= ptr;
            wdata     <= payload;
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            tcnt      <= '0;
            if (remaining == 16'd1) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/cmd_load_engine.sv
// Steers vertex/edge CMD pulses into two independent load sessions and keeps sticky error flags.
// Writes, BUSY and done appear one cycle after the command; there is no backpressure on CMD.
module cmd_load_engine
  import gpu_cmd_pkg::*;
#(
  parameter int VTX_AW         = 10,
  parameter int EDG_AW         = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [7:0]        CMD,
  input  logic [31:0]       payload,
  output logic [7:0]        BUSY,
  output logic              vtx_we,
  output logic [VTX_AW-1:0] vtx_addr,
  output logic [31:0]       vtx_wdata,
  output logic              edg_we,
  output logic [EDG_AW-1:0] edg_addr,
  output logic [31:0]       edg_wdata,
  output logic [1:0]        load_done,
  output logic [1:0]        err_overflow,
  output logic [1:0]        err_timeout
);
  logic vtx_busy, edg_busy, vtx_done, edg_done;
  logic vtx_ovf, edg_ovf, vtx_tmo, edg_tmo;
  logic unused_cmd;

  assign unused_cmd = ^{CMD[CMD_SWAP], CMD[7:6]};

  load_session #(.AW(VTX_AW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_vtx (
    .clk(CLK), .rst_n(rst_n),
    .cmd_begin(CMD[CMD_LVB]), .cmd_cont(CMD[CMD_LVC]), .payload(payload),
    .busy(vtx_busy), .we(vtx_we), .addr(vtx_addr), .wdata(vtx_wdata),
    .done(vtx_done), .ovf_hit(vtx_ovf), .tmo_hit(vtx_tmo)
  );

  load_session #(.AW(EDG_AW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_edg (
    .clk(CLK), .rst_n(rst_n),
    .cmd_begin(CMD[CMD_LEB]), .cmd_cont(CMD[CMD_LEC]), .payload(payload),
    .busy(edg_busy), .we(edg_we), .addr(edg_addr), .wdata(edg_wdata),
    .done(edg_done), .ovf_hit(edg_ovf), .tmo_hit(edg_tmo)
  );

  assign BUSY      = {3'b000, edg_busy, 1'b0, vtx_busy, 2'b00};
  assign load_done = {edg_done, vtx_done};

  // A new error in the same cycle as CLEAN survives the clear
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow <= 2'b00;
      err_timeout  <= 2'b00;
    end else begin
      err_overflow <= (err_overflow & ~{2{CMD[CMD_CLEAN]}}) | {edg_ovf, vtx_ovf};
      err_timeout  <= (err_timeout  & ~{2{CMD[CMD_CLEAN]}}) | {edg_tmo, vtx_tmo};
    end
  end
endmodule

// File: tb/tb_cmd_load_engine.sv
// Bench for cmd_load_engine: vector table, corner-case sequences, and randomized traffic vs a session model.
module tb_cmd_load_engine;
  localparam int AW = 10;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    CMD = 8'h00;
  logic [31:0]   payload = 32'h0;
  logic [7:0]    BUSY;
  logic          vtx_we, edg_we;
  logic [AW-1:0] vtx_addr, edg_addr;
  logic [31:0]   vtx_wdata, edg_wdata;
  logic [1:0]    load_done, err_overflow, err_timeout;

  cmd_load_engine #(.VTX_AW(AW), .EDG_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .rst_n(rst_n), .CMD(CMD), .payload(payload), .BUSY(BUSY),
    .vtx_we(vtx_we), .vtx_addr(vtx_addr), .vtx_wdata(vtx_wdata),
    .edg_we(edg_we), .edg_addr(edg_addr), .edg_wdata(edg_wdata),
    .load_done(load_done), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference: each session is an open window [ptr, ptr+left) plus the cycle of its last activity
  bit          m_act[2];
  int          m_ptr[2];
  int          m_left[2];
  int          m_last[2];
  bit          m_ovf[2];
  bit          m_tmo[2];
  int          cyc = 0;
  bit          e_we[2];
  int          e_addr[2];
  logic [31:0] e_data[2];
  bit          e_done[2];
  int          vwr_cnt = 0;
  bit          seen_done[2];

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] pl;
    logic [7:0]  busy;
    logic        vwe;
    logic        ewe;
    logic [9:0]  vaddr;
    logic [31:0] vdata;
    logic [1:0]  done;
    logic [1:0]  ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_act[s] = 0; m_ptr[s] = 0; m_left[s] = 0; m_last[s] = 0;
      m_ovf[s] = 0; m_tmo[s] = 0; e_we[s] = 0; e_done[s] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] c, input logic [31:0] p);
    bit set_ovf[2];
    bit set_tmo[2];
    for (int s = 0; s < 2; s++) begin
      bit beg, cont;
      int base, n;
      beg = c[2 + 2 * s];
      cont = c[3 + 2 * s];
      base = int'(p[31:16]);
      n = int'(p[15:0]);
      set_ovf[s] = 0; set_tmo[s] = 0;
      e_we[s] = 0; e_done[s] = 0;
      if (!m_act[s]) begin
        if (beg) begin
          if (n == 0) e_done[s] = 1;
          else if (base + n > (1 << AW)) set_ovf[s] = 1;
          else begin
            m_act[s] = 1; m_ptr[s] = base; m_left[s] = n; m_last[s] = cyc;
          end
        end
      end else if (cont) begin
        e_we[s] = 1; e_addr[s] = m_ptr[s]; e_data[s] = p;
        m_ptr[s]++; m_left[s]--; m_last[s] = cyc;
        if (m_left[s] == 0) begin m_act[s] = 0; e_done[s] = 1; end
      end else if (cyc - m_last[s] >= TO) begin
        m_act[s] = 0; set_tmo[s] = 1;
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (c[1]) begin m_ovf[s] = 0; m_tmo[s] = 0; end
      m_ovf[s] |= set_ovf[s];
      m_tmo[s] |= set_tmo[s];
    end
    cyc++;
  endtask

  task automatic cyc_step(input logic [7:0] c, input logic [31:0] p);
    CMD = c;
    payload = p;
    model_step(c, p);
    @(posedge CLK);
    #1;
    check("busy", 32'(BUSY), 32'({3'b0, m_act[1], 1'b0, m_act[0], 2'b0}));
    check("vtx_we", 32'(vtx_we), 32'(e_we[0]));
    check("edg_we", 32'(edg_we), 32'(e_we[1]));
    if (e_we[0]) begin
      check("vtx_addr", 32'(vtx_addr), 32'(e_addr[0]));
      check("vtx_wdata", vtx_wdata, e_data[0]);
    end
    if (e_we[1]) begin
      check("edg_addr", 32'(edg_addr), 32'(e_addr[1]));
      check("edg_wdata", edg_wdata, e_data[1]);
    end
    check("load_done", 32'(load_done), 32'({e_done[1], e_done[0]}));
    check("err_overflow", 32'(err_overflow), 32'({m_ovf[1], m_ovf[0]}));
    check("err_timeout", 32'(err_timeout), 32'({m_tmo[1], m_tmo[0]}));
    if (vtx_we) vwr_cnt++;
    if (load_done[0]) seen_done[0] = 1;
    if (load_done[1]) seen_done[1] = 1;
    CMD = 8'h00;
    payload = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    CMD = 8'h00;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_outputs", {BUSY, 4'h0, vtx_we, edg_we, load_done, err_overflow, err_timeout, 10'h0},
          32'h0);
    check("rst_addr", {6'h0, vtx_addr, 6'h0, edg_addr}, 32'h0);
    rst_n = 1'b1;
  endtask

  vec_t vt[$];

  initial begin
    int n;
    // cmd, payload, busy, vwe, ewe, vaddr, vdata, done, ovf
    vt.push_back('{8'h04, 32'h0010_0003, 8'h04, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b00});
    vt.push_back('{8'h08, 32'h0000_00A0, 8'h04, 1'b1, 1'b0, 10'h010, 32'hA0, 2'b00, 2'b00});
    vt.push_back('{8'h08, 32'h0000_00A1, 8'h04, 1'b1, 1'b0, 10'h011, 32'hA1, 2'b00, 2'b00});
    vt.push_back('{8'h08, 32'h0000_00A2, 8'h00, 1'b1, 1'b0, 10'h012, 32'hA2, 2'b01, 2'b00});
    vt.push_back('{8'h00, 32'h0,         8'h00, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b00});
    vt.push_back('{8'h10, 32'h03FE_0003, 8'h00, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b10});
    vt.push_back('{8'h20, 32'h0000_0077, 8'h00, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b10});
    vt.push_back('{8'h02, 32'h0,         8'h00, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b00});
    vt.push_back('{8'h04, 32'h0020_0000, 8'h00, 1'b0, 1'b0, 10'h000, 32'h0,  2'b01, 2'b00});
    vt.push_back('{8'h08, 32'h0000_0055, 8'h00, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b00});
    vt.push_back('{8'h04, 32'h03FF_0001, 8'h04, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b00});
    vt.push_back('{8'h08, 32'h0000_00BB, 8'h00, 1'b1, 1'b0, 10'h3FF, 32'hBB, 2'b01, 2'b00});
    vt.push_back('{8'h04, 32'h0100_0002, 8'h04, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b00});
    vt.push_back('{8'h04, 32'h0200_0005, 8'h04, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b00});
    vt.push_back('{8'h08, 32'h0000_0011, 8'h04, 1'b1, 1'b0, 10'h100, 32'h11, 2'b00, 2'b00});
    vt.push_back('{8'h08, 32'h0000_0022, 8'h00, 1'b1, 1'b0, 10'h101, 32'h22, 2'b01, 2'b00});
    vt.push_back('{8'hC1, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, 10'h000, 32'h0,  2'b00, 2'b00});

    do_reset();

    foreach (vt[i]) begin
      cyc_step(vt[i].cmd, vt[i].pl);
      check("tbl_busy", 32'(BUSY), 32'(vt[i].busy));
      check("tbl_vwe", 32'(vtx_we), 32'(vt[i].vwe));
      check("tbl_ewe", 32'(edg_we), 32'(vt[i].ewe));
      if (vt[i].vwe) begin
        check("tbl_vaddr", 32'(vtx_addr), 32'(vt[i].vaddr));
        check("tbl_vdata", vtx_wdata, vt[i].vdata);
      end
      check("tbl_done", 32'(load_done), 32'(vt[i].done));
      check("tbl_ovf", 32'(err_overflow), 32'(vt[i].ovf));
    end

    // Interleaved vertex/edge sessions
    seen_done[0] = 0; seen_done[1] = 0;
    cyc_step(8'h04, 32'h0040_0002);
    cyc_step(8'h10, 32'h0080_0002);
    check("overlap_busy", 32'(BUSY), 32'h14);
    cyc_step(8'h08, 32'h0000_0B00);
    cyc_step(8'h20, 32'h0000_0E00);
    check("ilv_edg_addr", 32'(edg_addr), 32'h080);
    cyc_step(8'h08, 32'h0000_0B01);
    cyc_step(8'h20, 32'h0000_0E01);
    check("ilv_both_done", 32'({seen_done[1], seen_done[0]}), 32'h3);

    // Timeout after 8 idle cycles, exactly one write
    n = vwr_cnt;
    cyc_step(8'h04, 32'h0000_0004);
    cyc_step(8'h08, 32'h0000_00C0);
    repeat (7) cyc_step(8'h00, 32'h0);
    check("tmo_still_busy", 32'(BUSY[2]), 32'h1);
    cyc_step(8'h00, 32'h0);
    check("tmo_busy_clear", 32'(BUSY[2]), 32'h0);
    check("tmo_err", 32'(err_timeout), 32'h1);
    check("tmo_one_write", 32'(vwr_cnt - n), 32'h1);
    cyc_step(8'h02, 32'h0);
    // CONT in the firing cycle keeps the session alive
    cyc_step(8'h04, 32'h0000_0004);
    cyc_step(8'h08, 32'h0000_00D0);
    repeat (7) cyc_step(8'h00, 32'h0);
    cyc_step(8'h08, 32'h0000_00D1);
    check("tmo_cont_wins", 32'(BUSY[2]), 32'h1);
    cyc_step(8'h08, 32'h0000_00D2);
    cyc_step(8'h08, 32'h0000_00D3);
    check("tmo_no_err", 32'(err_timeout), 32'h0);

    // Reset in the middle of a load
    cyc_step(8'h04, 32'h0050_0005);
    cyc_step(8'h08, 32'h0000_0001);
    cyc_step(8'h08, 32'h0000_0002);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(BUSY), 32'h0);
    check("midrst_done", 32'(load_done), 32'h0);
    do_reset();
    cyc_step(8'h04, 32'h0070_0002);
    cyc_step(8'h08, 32'h0000_0F00);
    check("restart_addr", 32'(vtx_addr), 32'h070);
    cyc_step(8'h08, 32'h0000_0F01);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [7:0]  c;
      logic [31:0] p;
      r = $urandom_range(0, 15);
      p = $urandom();
      c = 8'h00;
      case (r)
        4:  begin c = 8'h04; p = {16'($urandom_range(0, 1030)), 16'($urandom_range(0, 12))}; end
        5:  begin c = 8'h10; p = {16'($urandom_range(0, 1030)), 16'($urandom_range(0, 12))}; end
        6, 7, 8:   c = 8'h08;
        9, 10, 11: c = 8'h20;
        12: c = 8'h02;
        13: c = 8'h01;
        14: c = 8'h80;
        15: c = 8'h40;
        default: c = 8'h00;
      endcase
      cyc_step(c, p);
      if (k % 250 == 0) repeat (10) cyc_step(8'h00, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
